// File: rtl/reg_ctrl_pkg.sv
// rtl/reg_ctrl_pkg.sv - shared types and defaults for the register-file access controller
package reg_ctrl_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 3;
  localparam int NUM_REGS_DEF = 2 ** ADDR_W_DEF;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/reg_ctrl8x32.sv
// rtl/reg_ctrl8x32.sv - register-file access controller: clear sequence, 1-cycle reads, writeback, forwarding
module reg_ctrl8x32
  import reg_ctrl_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              init_done,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rs0,
  input  logic [ADDR_W-1:0] rs1,
  output logic              rd_rsp_valid,
  output logic [DATA_W-1:0] rd_rsp_data0,
  output logic [DATA_W-1:0] rd_rsp_data1,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rf_read,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_rAddr0,
  output logic [ADDR_W-1:0] rf_rAddr1,
  output logic [ADDR_W-1:0] rf_wAddr,
  output logic [DATA_W-1:0] rf_wData,
  input  logic [DATA_W-1:0] rf_rData0,
  input  logic [DATA_W-1:0] rf_rData1
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clr_last;

  logic              rd_fire;
  logic              wr_fire;
  logic              wr_to_zero;

  logic              rsp_valid_q;
  logic              zero0_q, zero1_q;
  logic              fwd0_q, fwd1_q;
  logic [DATA_W-1:0] fwd_data_q;
  logic [DATA_W-1:0] data0_q, data1_q;
  logic [DATA_W-1:0] rsp0, rsp1;

  assign clr_last     = (clr_cnt == LAST_ADDR);
  assign init_done    = (state == RUN);
  assign rd_req_ready = (state == RUN) && !clr_req;
  assign wr_ready     = (state == RUN) && !clr_req;
  assign rd_fire      = rd_req_valid && rd_req_ready;
  assign wr_fire      = wr_valid && wr_ready;
  assign wr_to_zero   = (ZERO_REG != 0) && (wr_addr == '0);

  assign rf_read   = rd_fire;
  assign rf_rAddr0 = rs0;
  assign rf_rAddr1 = rs1;

  // The clear sequence owns the write port; in RUN it carries accepted writebacks.
  always_comb begin
    rf_write = 1'b0;
    rf_wAddr = wr_addr;
    rf_wData = wr_data;
    if (state == CLEAR) begin
      rf_write = 1'b1;
      rf_wAddr = clr_cnt;
      rf_wData = '0;
    end else begin
      rf_write = wr_fire && !wr_to_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_last) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (clr_req) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
        default: begin
          state   <= CLEAR;
          clr_cnt <= '0;
        end
      endcase
    end
  end

  // Forwarding decisions are captured at accept time; the file's data arrives a cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      zero0_q     <= 1'b0;
      zero1_q     <= 1'b0;
      fwd0_q      <= 1'b0;
      fwd1_q      <= 1'b0;
      fwd_data_q  <= '0;
    end else begin
      rsp_valid_q <= rd_fire;
      if (rd_fire) begin
        zero0_q <= (ZERO_REG != 0) && (rs0 == '0);
        zero1_q <= (ZERO_REG != 0) && (rs1 == '0);
        fwd0_q  <= wr_fire && !wr_to_zero && (rs0 == wr_addr);
        fwd1_q  <= wr_fire && !wr_to_zero && (rs1 == wr_addr);
      end
      if (wr_fire) begin
        fwd_data_q <= wr_data;
      end
    end
  end

  assign rsp0 = zero0_q ? '0 : (fwd0_q ? fwd_data_q : rf_rData0);
  assign rsp1 = zero1_q ? '0 : (fwd1_q ? fwd_data_q : rf_rData1);

  // Hold the last delivered operands between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      data0_q <= '0;
      data1_q <= '0;
    end else if (rsp_valid_q) begin
      data0_q <= rsp0;
      data1_q <= rsp1;
    end
  end

  assign rd_rsp_valid = rsp_valid_q;
  assign rd_rsp_data0 = rsp_valid_q ? rsp0 : data0_q;
  assign rd_rsp_data1 = rsp_valid_q ? rsp1 : data1_q;

endmodule

// File: tb/tb_reg_ctrl8x32.sv
// tb/tb_reg_ctrl8x32.sv - table-driven bench for reg_ctrl8x32 with a behavioural 8x32 register file
module tb_reg_ctrl8x32;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_req;
  logic        init_done;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [2:0]  rs0, rs1;
  logic        rd_rsp_valid;
  logic [31:0] rd_rsp_data0, rd_rsp_data1;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rf_read, rf_write;
  logic [2:0]  rf_rAddr0, rf_rAddr1, rf_wAddr;
  logic [31:0] rf_wData;
  logic [31:0] rf_rData0 = '0;
  logic [31:0] rf_rData1 = '0;

  logic        fill;
  logic [31:0] rf_mem [8];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_ctrl8x32 #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .init_done(init_done),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rs0(rs0), .rs1(rs1),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data0(rd_rsp_data0), .rd_rsp_data1(rd_rsp_data1),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rf_read(rf_read), .rf_write(rf_write),
    .rf_rAddr0(rf_rAddr0), .rf_rAddr1(rf_rAddr1), .rf_wAddr(rf_wAddr),
    .rf_wData(rf_wData), .rf_rData0(rf_rData0), .rf_rData1(rf_rData1)
  );

  // Register file with registered reads; pre-filled with garbage so the clear is observable.
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= 32'hC0DE_0000 | i;
    end else begin
      if (rf_write) rf_mem[rf_wAddr] <= rf_wData;
      if (rf_read) begin
        rf_rData0 <= rf_mem[rf_rAddr0];
        rf_rData1 <= rf_mem[rf_rAddr1];
      end
    end
  end

  typedef struct {
    logic        wv;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic        rv;
    logic [2:0]  r0;
    logic [2:0]  r1;
    logic        e_wr;
    logic        e_v;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(logic wv, logic [2:0] wa, logic [31:0] wd,
                              logic rv, logic [2:0] r0, logic [2:0] r1,
                              logic e_wr, logic e_v, logic [31:0] e_d0, logic [31:0] e_d1);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wd = wd; v.rv = rv; v.r0 = r0; v.r1 = r1;
    v.e_wr = e_wr; v.e_v = e_v; v.e_d0 = e_d0; v.e_d1 = e_d1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [2:0] wa, input logic [31:0] wd,
                       input logic rv, input logic [2:0] r0, input logic [2:0] r1);
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_req_valid = rv; rs0 = r0; rs1 = r1;
  endtask

  task automatic check_clear_cycle(input int k);
    chk($sformatf("clr%0d_write", k), {31'd0, rf_write}, 32'd1);
    chk($sformatf("clr%0d_waddr", k), {29'd0, rf_wAddr}, k);
    chk($sformatf("clr%0d_wdata", k), rf_wData, 32'd0);
    chk($sformatf("clr%0d_init", k), {31'd0, init_done}, 32'd0);
    chk($sformatf("clr%0d_ready", k), {30'd0, rd_req_ready, wr_ready}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(1, 3, 32'hDEADBEEF, 0, 0, 0, 1, 0, 32'h0, 32'h0);
    vecs[1]  = mk(0, 0, 32'h0,        1, 3, 5, 0, 0, 32'h0, 32'h0);
    vecs[2]  = mk(1, 6, 32'h12345678, 1, 6, 6, 1, 1, 32'hDEADBEEF, 32'h0);
    vecs[3]  = mk(1, 0, 32'hFFFFFFFF, 1, 0, 3, 0, 1, 32'h12345678, 32'h12345678);
    vecs[4]  = mk(0, 0, 32'h0,        1, 0, 6, 0, 1, 32'h0, 32'hDEADBEEF);
    vecs[5]  = mk(1, 5, 32'hA5A5A5A5, 1, 5, 3, 1, 1, 32'h0, 32'h12345678);
    vecs[6]  = mk(1, 5, 32'h0BADF00D, 1, 5, 5, 1, 1, 32'hA5A5A5A5, 32'hDEADBEEF);
    vecs[7]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h0BADF00D, 32'h0BADF00D);
    vecs[8]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0BADF00D, 32'h0BADF00D);
    vecs[9]  = mk(1, 0, 32'h00000001, 1, 0, 0, 0, 0, 32'h0BADF00D, 32'h0BADF00D);
    vecs[10] = mk(1, 7, 32'h77777777, 1, 1, 2, 1, 1, 32'h0, 32'h0);
    vecs[11] = mk(0, 0, 32'h0,        1, 7, 5, 0, 1, 32'h0, 32'h0);
    vecs[12] = mk(0, 0, 32'h0,        1, 6, 3, 0, 1, 32'h77777777, 32'h0BADF00D);
    vecs[13] = mk(0, 0, 32'h0,        1, 1, 7, 0, 1, 32'h12345678, 32'hDEADBEEF);
    vecs[14] = mk(0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h0, 32'h77777777);

    rst = 1'b1; fill = 1'b1; clr_req = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", {31'd0, rd_rsp_valid}, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_ready", {30'd0, rd_req_ready, wr_ready}, 32'd0);
    chk("rst_data0", rd_rsp_data0, 32'd0);
    chk("rst_data1", rd_rsp_data1, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0; fill = 1'b0;

    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      check_clear_cycle(k);
    end
    @(negedge clk);
    chk("init_done_after_clear", {31'd0, init_done}, 32'd1);

    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1 drive(vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].rv, vecs[i].r0, vecs[i].r1);
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), {30'd0, rd_req_ready, wr_ready}, 32'd3);
      chk($sformatf("v%0d_rf_write", i), {31'd0, rf_write}, {31'd0, vecs[i].e_wr});
      chk($sformatf("v%0d_rf_read", i), {31'd0, rf_read}, {31'd0, vecs[i].rv});
      if (vecs[i].e_wr) chk($sformatf("v%0d_waddr", i), {29'd0, rf_wAddr}, {29'd0, vecs[i].wa});
      chk($sformatf("v%0d_rsp_valid", i), {31'd0, rd_rsp_valid}, {31'd0, vecs[i].e_v});
      chk($sformatf("v%0d_data0", i), rd_rsp_data0, vecs[i].e_d0);
      chk($sformatf("v%0d_data1", i), rd_rsp_data1, vecs[i].e_d1);
    end

    // Clear requested the cycle after a read; that read's response must still appear.
    @(posedge clk);
    #1 drive(0, 0, 0, 1, 7, 3);
    @(negedge clk);
    chk("cm_read_fire", {31'd0, rf_read}, 32'd1);
    @(posedge clk);
    #1 clr_req = 1'b1; drive(1, 2, 32'h55555555, 1, 1, 1);
    @(negedge clk);
    chk("cm_ready", {30'd0, rd_req_ready, wr_ready}, 32'd0);
    chk("cm_rf_read", {31'd0, rf_read}, 32'd0);
    chk("cm_rf_write", {31'd0, rf_write}, 32'd0);
    chk("cm_init_still", {31'd0, init_done}, 32'd1);
    chk("cm_rsp_valid", {31'd0, rd_rsp_valid}, 32'd1);
    chk("cm_data0", rd_rsp_data0, 32'h77777777);
    chk("cm_data1", rd_rsp_data1, 32'hDEADBEEF);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1 clr_req = (k == 2); drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check_clear_cycle(k);
      if (k == 0) chk("cm_rsp_gone", {31'd0, rd_rsp_valid}, 32'd0);
    end
    @(posedge clk);
    #1 clr_req = 1'b0;
    @(negedge clk);
    chk("cm_init_done", {31'd0, init_done}, 32'd1);

    for (int j = 0; j < 5; j++) begin
      @(posedge clk);
      if (j < 4) #1 drive(0, 0, 0, 1, 3'(2 * j), 3'(2 * j + 1));
      else #1 drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      if (j > 0) begin
        chk($sformatf("zr%0d_valid", j), {31'd0, rd_rsp_valid}, 32'd1);
        chk($sformatf("zr%0d_data0", j), rd_rsp_data0, 32'd0);
        chk($sformatf("zr%0d_data1", j), rd_rsp_data1, 32'd0);
      end
    end

    // Reset arriving with a read in flight drops the response and restarts the clear.
    @(posedge clk);
    #1 drive(0, 0, 0, 1, 7, 6); rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mr_rsp_valid", {31'd0, rd_rsp_valid}, 32'd0);
    check_clear_cycle(0);
    for (int k = 1; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_clear_cycle(k);
    end
    @(negedge clk);
    chk("mr_init_done", {31'd0, init_done}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
